// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between two requesters.
//   Requester 0 is the CPU load/store path, requester 1 is the loader/debug port.
//   One transaction at a time; round-robin on ties; out-of-range addresses are
//   rejected with err and never reach the memory.
//
// Ports:
//   clk, reset                   clock (rising edge), synchronous active-high reset
//   req*/we*/addr*/wdata*        request, write flag, word address, write data (held until done)
//   gnt*                         one-cycle pulse, request accepted
//   done*/err*                   one-cycle completion pulse, err = address out of range
//   rdata*                       last read data per requester
//   busy                         arbiter not idle
//   mem_*                        single-port memory interface
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  err0,

  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err1,

  output logic                  busy,

  output logic [ADDR_WIDTH-1:0] mem_Address,
  output logic [DATA_WIDTH-1:0] mem_Write_Data,
  output logic                  mem_MemWrite,
  output logic                  mem_MemRead,
  input  logic [DATA_WIDTH-1:0] mem_Read_Data
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  // One extra bit so the range check is a full-width unsigned compare for any DEPTH.
  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          LastCnt  = 4'(ACCESS_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q, winner_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                  err_q, err_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  // Arbitration decision, meaningful only in StIdle with at least one request.
  logic                  pick;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_in_range;

  always_comb begin
    // On a tie the requester that did not win last time goes next.
    if (req0 && req1) begin
      pick = ~last_grant_q;
    end else begin
      pick = req1;
    end
    sel_we       = pick ? we1    : we0;
    sel_addr     = pick ? addr1  : addr0;
    sel_wdata    = pick ? wdata1 : wdata0;
    sel_in_range = ({1'b0, sel_addr} < DepthExt);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    err_d        = err_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          winner_d     = pick;
          last_grant_d = pick;
          cmd_we_d     = sel_we;
          cmd_addr_d   = sel_addr;
          cmd_wdata_d  = sel_wdata;
          gnt0_d       = ~pick;
          gnt1_d       = pick;
          cnt_d        = 4'd0;
          if (sel_in_range) begin
            err_d   = 1'b0;
            state_d = StAccess;
          end else begin
            // Rejected: skip the memory entirely and report straight away.
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end

      StAccess: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (!cmd_we_q) begin
            if (winner_q) begin
              rdata1_d = mem_Read_Data;
            end else begin
              rdata0_d = mem_Read_Data;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      err_q        <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      cnt_q        <= 4'd0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      err_q        <= err_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Outputs decode from state, so the reset of state_q alone drops strobes and done.
  logic in_access;
  logic in_done;

  always_comb begin
    in_access      = (state_q == StAccess);
    in_done        = (state_q == StDone);
    gnt0           = gnt0_q;
    gnt1           = gnt1_q;
    done0          = in_done & ~winner_q;
    done1          = in_done & winner_q;
    err0           = done0 & err_q;
    err1           = done1 & err_q;
    rdata0         = rdata0_q;
    rdata1         = rdata1_q;
    busy           = (state_q != StIdle);
    // Both strobes derive from the single cmd_we_q, so they cannot overlap.
    mem_MemWrite   = in_access & cmd_we_q;
    mem_MemRead    = in_access & ~cmd_we_q;
    mem_Address    = in_access ? cmd_addr_q  : '0;
    mem_Write_Data = in_access ? cmd_wdata_q : '0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port memory.
module tb_data_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int ACC   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, err0, err1, busy;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_Address;
  logic [DW-1:0] mem_Write_Data, mem_Read_Data;
  logic          mem_MemWrite, mem_MemRead;

  int checks   = 0;
  int failures = 0;
  int excl_viol = 0;
  int dual_gnt  = 0;

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .ACCESS_CYCLES(ACC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req0          (req0),
    .we0           (we0),
    .addr0         (addr0),
    .wdata0        (wdata0),
    .gnt0          (gnt0),
    .done0         (done0),
    .rdata0        (rdata0),
    .err0          (err0),
    .req1          (req1),
    .we1           (we1),
    .addr1         (addr1),
    .wdata1        (wdata1),
    .gnt1          (gnt1),
    .done1         (done1),
    .rdata1        (rdata1),
    .err1          (err1),
    .busy          (busy),
    .mem_Address   (mem_Address),
    .mem_Write_Data(mem_Write_Data),
    .mem_MemWrite  (mem_MemWrite),
    .mem_MemRead   (mem_MemRead),
    .mem_Read_Data (mem_Read_Data)
  );

  // Memory: asynchronous read, write on rising edge; reset reloads a known pattern.
  assign mem_Read_Data = (mem_MemRead && mem_Address < 32'(DEPTH)) ? mem[mem_Address[7:0]] : '0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == 7) ? 32'd7 : {16'hA5A5, 16'(i)};
      end
    end else if (mem_MemWrite && mem_Address < 32'(DEPTH)) begin
      mem[mem_Address[7:0]] <= mem_Write_Data;
    end
  end

  always @(negedge clk) begin
    if (mem_MemWrite && mem_MemRead) excl_viol <= excl_viol + 1;
    if (gnt0 && gnt1) dual_gnt <= dual_gnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } txn_t;

  txn_t vec [10];

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
  endtask

  // Drives one request at a negedge (cycle T0) and observes T1.. at later negedges.
  task automatic run_txn(input int idx, input txn_t t);
    int   gnt_cyc  = -1;
    int   done_cyc = -1;
    int   rd_n = 0;
    int   wr_n = 0;
    logic busy_seen = 1'b0;
    logic err_seen  = 1'b0;
    logic addr_ok   = 1'b1;
    logic quiet     = 1'b1;
    string p;
    p = $sformatf("vec%0d", idx);
    @(negedge clk);
    if (t.sel == 0) begin
      req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
    end else begin
      req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_MemRead) rd_n++;
      if (mem_MemWrite) wr_n++;
      if ((mem_MemRead || mem_MemWrite) && (mem_Address !== t.addr)) addr_ok = 1'b0;
      if (mem_MemWrite && (mem_Write_Data !== t.wdata)) addr_ok = 1'b0;
      if (t.sel == 0) begin
        if (gnt1 || done1) quiet = 1'b0;
        if (gnt0 && gnt_cyc < 0) begin gnt_cyc = c; busy_seen = busy; end
        if (done0) begin done_cyc = c; err_seen = err0; req0 = 1'b0; break; end
      end else begin
        if (gnt0 || done0) quiet = 1'b0;
        if (gnt1 && gnt_cyc < 0) begin gnt_cyc = c; busy_seen = busy; end
        if (done1) begin done_cyc = c; err_seen = err1; req1 = 1'b0; break; end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check({p, "_gnt_cycle"}, 32'(gnt_cyc), 32'd1);
    check({p, "_done_cycle"}, 32'(done_cyc), t.exp_err ? 32'd1 : 32'(ACC + 1));
    check({p, "_busy_at_gnt"}, 32'(busy_seen), 32'd1);
    check({p, "_err"}, 32'(err_seen), 32'(t.exp_err));
    check({p, "_read_strobes"}, 32'(rd_n), (!t.exp_err && !t.we) ? 32'(ACC) : 32'd0);
    check({p, "_write_strobes"}, 32'(wr_n), (!t.exp_err && t.we) ? 32'(ACC) : 32'd0);
    check({p, "_mem_addr_data"}, 32'(addr_ok), 32'd1);
    check({p, "_loser_quiet"}, 32'(quiet), 32'd1);
    check({p, "_rdata0"}, rdata0, t.exp_rd0);
    check({p, "_rdata1"}, rdata1, t.exp_rd1);
  endtask

  initial begin
    int order [4];
    int dcyc  [4];
    int ng;
    int nd;
    logic seen_done;

    vec[0] = '{0, 1'b0, 32'd7,          32'h0,         1'b0, 32'd7,         32'h0};
    vec[1] = '{1, 1'b1, 32'd15,         32'h0000000F,  1'b0, 32'd7,         32'h0};
    vec[2] = '{1, 1'b0, 32'd15,         32'h0,         1'b0, 32'd7,         32'h0000000F};
    vec[3] = '{0, 1'b0, 32'd256,        32'h0,         1'b1, 32'd7,         32'h0000000F};
    vec[4] = '{0, 1'b1, 32'd255,        32'h12345678,  1'b0, 32'd7,         32'h0000000F};
    vec[5] = '{0, 1'b0, 32'd255,        32'h0,         1'b0, 32'h12345678,  32'h0000000F};
    vec[6] = '{1, 1'b0, 32'h80000000,   32'h0,         1'b1, 32'h12345678,  32'h0000000F};
    vec[7] = '{1, 1'b0, 32'd200,        32'h0,         1'b0, 32'h12345678,  32'hA5A500C8};
    vec[8] = '{0, 1'b1, 32'd0,          32'h0000CAFE,  1'b0, 32'h12345678,  32'hA5A500C8};
    vec[9] = '{1, 1'b0, 32'd0,          32'h0,         1'b0, 32'h12345678,  32'h0000CAFE};

    // Reset state, sampled while reset is still asserted.
    do_reset();
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_done", 32'({done0, done1}), 32'd0);
    check("rst_err", 32'({err0, err1}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({mem_MemWrite, mem_MemRead}), 32'd0);
    check("rst_mem_addr", mem_Address, 32'd0);
    check("rst_mem_wdata", mem_Write_Data, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(i, vec[i]);

    // Field change during access: the latched address must be used.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
    @(negedge clk);
    check("fc_gnt0", 32'(gnt0), 32'd1);
    check("fc_addr_t1", mem_Address, 32'd7);
    addr0 = 32'd3;
    @(negedge clk);
    check("fc_addr_t2", mem_Address, 32'd7);
    check("fc_read_t2", 32'(mem_MemRead), 32'd1);
    @(negedge clk);
    check("fc_done0", 32'(done0), 32'd1);
    check("fc_rdata0", rdata0, 32'd7);
    req0 = 1'b0;

    // Round-robin with both requesters held high from reset.
    do_reset();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd15;
    ng = 0;
    nd = 0;
    for (int c = 1; c <= 40 && nd < 4; c++) begin
      @(negedge clk);
      if (ng < 4 && gnt0) begin order[ng] = 0; ng++; end
      if (ng < 4 && gnt1) begin order[ng] = 1; ng++; end
      if (done0 || done1) begin dcyc[nd] = c; nd++; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("rr_grant_count", 32'(ng), 32'd4);
    check("rr_done_count", 32'(nd), 32'd4);
    if (ng == 4) begin
      check("rr_order0", 32'(order[0]), 32'd0);
      check("rr_order1", 32'(order[1]), 32'd1);
      check("rr_order2", 32'(order[2]), 32'd0);
      check("rr_order3", 32'(order[3]), 32'd1);
    end
    if (nd == 4) begin
      check("rr_first_done", 32'(dcyc[0]), 32'(ACC + 1));
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rr_done_gap%0d", k), 32'(dcyc[k+1] - dcyc[k]), 32'(ACC + 2));
      end
    end
    check("rr_rdata0", rdata0, 32'd7);
    check("rr_rdata1", rdata1, 32'hA5A5000F);
    repeat (2) @(negedge clk);
    check("rr_idle_busy", 32'(busy), 32'd0);

    // Reset in the first access cycle of a write.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd3; wdata1 = 32'hDEAD;
    @(negedge clk);
    check("mr_gnt1", 32'(gnt1), 32'd1);
    check("mr_write_t1", 32'(mem_MemWrite), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mr_strobes", 32'({mem_MemWrite, mem_MemRead}), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_mem_addr", mem_Address, 32'd0);
    check("mr_rdata1", rdata1, 32'd0);
    req1 = 1'b0;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done0 || done1 || busy) seen_done = 1'b1;
    end
    check("mr_no_done_after", 32'(seen_done), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd15;
    @(negedge clk);
    check("mr_tie_gnt", 32'({gnt0, gnt1}), 32'b10);
    req1 = 1'b0;
    for (int c = 0; c < 10 && !done0; c++) @(negedge clk);
    check("mr_tie_done0", 32'(done0), 32'd1);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    check("mem_strobe_exclusive", 32'(excl_viol), 32'd0);
    check("gnt_exclusive", 32'(dual_gnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: requester 0 is the CPU load/store path, requester 1 is the loader/debug port.
- Accepts one transaction at a time and drives the memory's address, write-data, MemWrite and MemRead for a fixed number of cycles.
- Captures read data and returns a one-cycle done pulse to the winning requester.
- Uses round-robin arbitration, range-checks addresses and keeps MemWrite and MemRead mutually exclusive.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses (word addresses).
- DATA_WIDTH, 32, width of data paths.
- DEPTH, 256, number of valid memory words; legal addresses are 0..DEPTH-1.
- ACCESS_CYCLES, 2, cycles the memory strobes are held per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from requester 0 / 1; held high until done.
- we0 / we1  in  1  1 = write (SW), 0 = read (LW); held stable while req is high.
- addr0 / addr1  in  ADDR_WIDTH  word address; held stable while req is high.
- wdata0 / wdata1  in  DATA_WIDTH  write data; held stable while req is high.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted.
- done0 / done1  out  1  one-cycle pulse: transaction complete.
- rdata0 / rdata1  out  DATA_WIDTH  last read data per requester; held until that requester's next completed read.
- err0 / err1  out  1  valid with done; 1 = address out of range, no access performed.
- busy  out  1  high in any state other than IDLE.
- mem_Address  out  ADDR_WIDTH  to memory Address.
- mem_Write_Data  out  DATA_WIDTH  to memory Write_Data.
- mem_MemWrite  out  1  to memory MemWrite.
- mem_MemRead  out  1  to memory MemRead.
- mem_Read_Data  in  DATA_WIDTH  from memory Read_Data.

Behaviour:
- Reset values: state IDLE; all gnt, done, err = 0; rdata0 = rdata1 = 0; busy = 0; mem_Address = 0; mem_Write_Data = 0; both strobes = 0; last_grant = 1, so requester 0 wins the first tie.
- Reset asserted mid-transaction: the next edge forces all of the above. Strobes drop, no done is issued, and the requester must re-request.
- FSM states: IDLE, ACCESS, DONE.
- IDLE with no request: remains in IDLE.
- IDLE, exactly one req high: that requester wins.
- IDLE, both req high: the requester not equal to last_grant wins; last_grant is updated to the winner.
- On the winning edge: latch we, addr and wdata into the command register and register gnt for the following cycle.
  - addr < DEPTH: next state ACCESS.
  - addr >= DEPTH (unsigned compare at full ADDR_WIDTH): next state DONE with err set.
- ACCESS: mem_Address and mem_Write_Data come from the command register.
  - Exactly one strobe is high: mem_MemWrite = we, mem_MemRead = !we.
  - The strobe is held for exactly ACCESS_CYCLES cycles, counted by an internal counter reset on ACCESS entry.
  - gnt is high in the first ACCESS cycle only.
  - At the edge ending the last ACCESS cycle of a read, mem_Read_Data is captured into the winner's rdata. Writes leave rdata unchanged. Next state DONE.
- DONE: strobes = 0 and mem_Address/mem_Write_Data return to 0.
  - done is high for the winner for one cycle; err is high in the same cycle if out of range, otherwise 0.
  - The loser sees no gnt/done activity.
  - Next state IDLE.
- In-range latency: req sampled in cycle T0 → gnt at T1 → strobes at T1..T(ACCESS_CYCLES) → done at T(ACCESS_CYCLES+1). Default: done at T3.
- Out-of-range latency: gnt and done both at T1, err = 1, no strobe ever asserted, rdata unchanged.
- Throughput: a new grant is possible every ACCESS_CYCLES+2 cycles (one IDLE cycle between transactions).
- Request hold: requesters drop req at the edge where done is sampled. A req still high in the following IDLE cycle is a new request.
- A requester that keeps req high continuously is alternated with the other requester when both are pending; no starvation.
- Requests and field changes arriving during ACCESS/DONE are ignored until IDLE. The latched command is unaffected.
- MemWrite and MemRead are never high in the same cycle, including across state transitions and reset.

Test Plan:
- Read: preload word 7 = 7; req0 = 1, we0 = 0, addr0 = 7 at T0 → gnt0 at T1; mem_MemRead high T1–T2; done0 at T3; rdata0 = 7; err0 = 0; mem_MemWrite never high.
- Write then readback: req1 write addr 15, data 0x0000000F → mem_MemWrite high 2 cycles with mem_Address = 15; done1 at T3. Then req1 read addr 15 → rdata1 = 0x0000000F; rdata0 unchanged.
- Tie and round-robin: req0 and req1 both held high continuously after reset → grant order 0, 1, 0, 1; each done 4 cycles apart; gnt0 and gnt1 never high together.
- Out of range: req0 read addr 256 → gnt0 and done0 at T1 with err0 = 1; both strobes stay 0; rdata0 keeps its previous value. Then addr 255 is accepted with err0 = 0.
- Reset mid-access: reset asserted in the first ACCESS cycle of a write to addr 3 → next cycle all strobes 0, busy 0, no done1. The next tie after reset grants requester 0 first.
- Field change during access: addr0 changed from 7 to 3 during ACCESS → mem_Address stays 7 and rdata0 = 7.
